// File: rtl/dilithium_pkg.sv
// ---------------------------------------------------------------------------
// dilithium_pkg
// Shared constants and coefficient/product types for the Dilithium arithmetic
// datapath. The multiplier (mul_d_pipe) and the downstream Barrett reducer
// (red_d) both import this package, so the product type here is exactly what
// red_d expects on its input.
// ---------------------------------------------------------------------------
package dilithium_pkg;

    localparam int W_D = 23;
    localparam int Q_D = 8380417;

    typedef logic [W_D-1:0]   coeff_t;
    typedef logic [2*W_D-1:0] prod_t;

endpackage

// File: rtl/mul_d_stage.sv
// ---------------------------------------------------------------------------
// mul_d_stage
// One register slice of a valid/ready pipeline. It holds a payload plus its
// valid bit. The slice advances when it is empty or when the next slice (or
// the consumer) takes its current contents. An empty slice therefore accepts
// new data even when everything downstream is stalled, so bubbles collapse.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (clears valid and payload)
//   i_valid  upstream has a payload this cycle
//   o_ready  this slice advances this cycle (combinational from i_ready)
//   i_data   upstream payload
//   o_valid  this slice holds a payload
//   i_ready  downstream advances / consumes this cycle
//   o_data   held payload
// ---------------------------------------------------------------------------
module mul_d_stage #(
    parameter int PW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [PW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [PW-1:0] o_data
);

    logic          r_valid;
    logic [PW-1:0] r_data;
    logic          w_adv;

    assign w_adv   = !r_valid || i_ready;
    assign o_ready = w_adv;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Payload is only loaded on a real transfer so that a held value never
    // gets overwritten by garbage on a bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_adv) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/mul_d_pipe.sv
// ---------------------------------------------------------------------------
// mul_d_pipe
// Three-stage pipelined W x W unsigned multiplier for Dilithium coefficients,
// feeding the red_d Barrett reducer. Valid/ready handshake on both sides,
// full throughput, capacity of three operations, sideband tag carried with
// each product.
//
//   S1: register a, b, tag
//   S2: register partial products a*b[SPLIT-1:0] and a*b[W-1:SPLIT]
//   S3: register (pp_hi << SPLIT) + pp_lo  (output register)
//
// Optional build macro: MUL_D_RANGE_CHECK_EN
//   When defined, a flag (a >= Q || b >= Q) is captured in S1, travels with
//   the data and appears on err_o together with the affected product.
//   When undefined, no flag is carried and err_o is tied low.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   valid_i    input operands valid
//   ready_o    block accepts operands this cycle
//   a_i, b_i   operands, expected in [0, Q-1] (larger values still exact)
//   tag_i      sideband tag
//   valid_o    product valid
//   ready_i    downstream ready
//   product_o  exact unsigned a*b
//   tag_o      tag accompanying product_o
//   err_o      range error flag (range-check build only)
// ---------------------------------------------------------------------------
module mul_d_pipe
    import dilithium_pkg::*;
#(
    parameter int W     = W_D,
    parameter int Q     = Q_D,
    parameter int SPLIT = 12,
    parameter int TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [2*W-1:0]   product_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             err_o
);

`ifdef MUL_D_RANGE_CHECK_EN
    localparam int FW = 1;
`else
    localparam int FW = 0;
`endif

    localparam int LO_W = W + SPLIT;
    localparam int HI_W = 2*W - SPLIT;
    localparam int S1_W = 2*W + TAG_W + FW;
    localparam int S2_W = LO_W + HI_W + TAG_W + FW;
    localparam int S3_W = 2*W + TAG_W + FW;

    logic [S1_W-1:0] w_s1_in, w_s1_out;
    logic [S2_W-1:0] w_s2_in, w_s2_out;
    logic [S3_W-1:0] w_s3_in, w_s3_out;
    logic            w_s1_valid, w_s2_valid;
    logic            w_s2_ready, w_s3_ready;

    logic [W-1:0]    w_a1, w_b1;
    logic [LO_W-1:0] w_pp_lo, w_pp_lo2;
    logic [HI_W-1:0] w_pp_hi, w_pp_hi2;
    logic [2*W-1:0]  w_prod;

    // Operand b is split so each stage-2 multiplier stays narrow; the upper
    // slice is shifted back into place in stage 3.
    assign w_a1    = w_s1_out[TAG_W +: W];
    assign w_b1    = w_s1_out[TAG_W+W +: W];
    assign w_pp_lo = LO_W'(w_a1) * LO_W'(w_b1[SPLIT-1:0]);
    assign w_pp_hi = HI_W'(w_a1) * HI_W'(w_b1[W-1:SPLIT]);

    assign w_pp_lo2 = w_s2_out[TAG_W +: LO_W];
    assign w_pp_hi2 = w_s2_out[TAG_W+LO_W +: HI_W];
    assign w_prod   = ((2*W)'(w_pp_hi2) << SPLIT) + (2*W)'(w_pp_lo2);

`ifdef MUL_D_RANGE_CHECK_EN
    localparam logic [W:0] Q_EXT = Q[W:0];
    logic w_flag;
    assign w_flag  = ({1'b0, a_i} >= Q_EXT) || ({1'b0, b_i} >= Q_EXT);
    assign w_s1_in = {w_flag, b_i, a_i, tag_i};
    assign w_s2_in = {w_s1_out[S1_W-1], w_pp_hi, w_pp_lo, w_s1_out[TAG_W-1:0]};
    assign w_s3_in = {w_s2_out[S2_W-1], w_prod, w_s2_out[TAG_W-1:0]};
    // Gated by valid so the flag never shows on an idle output.
    assign err_o   = w_s3_out[S3_W-1] && valid_o;
`else
    assign w_s1_in = {b_i, a_i, tag_i};
    assign w_s2_in = {w_pp_hi, w_pp_lo, w_s1_out[TAG_W-1:0]};
    assign w_s3_in = {w_prod, w_s2_out[TAG_W-1:0]};
    assign err_o   = 1'b0;
`endif

    assign product_o = w_s3_out[TAG_W +: 2*W];
    assign tag_o     = w_s3_out[TAG_W-1:0];

    // Ready ripples backwards combinationally: each slice advances when it
    // is empty or its successor advances.
    mul_d_stage #(.PW(S1_W)) u_s1 (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_valid (valid_i),
        .o_ready (ready_o),
        .i_data  (w_s1_in),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_out)
    );

    mul_d_stage #(.PW(S2_W)) u_s2 (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  (w_s2_in),
        .o_valid (w_s2_valid),
        .i_ready (w_s3_ready),
        .o_data  (w_s2_out)
    );

    mul_d_stage #(.PW(S3_W)) u_s3 (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_valid (w_s2_valid),
        .o_ready (w_s3_ready),
        .i_data  (w_s3_in),
        .o_valid (valid_o),
        .i_ready (ready_i),
        .o_data  (w_s3_out)
    );

endmodule

// File: tb/tb_mul_d_pipe.sv
// ---------------------------------------------------------------------------
// tb_mul_d_pipe
// Self-checking bench for mul_d_pipe. Directed scenarios plus a randomized
// stream checked against a queue-based reference model that computes each
// expected product with plain multiplication.
// ---------------------------------------------------------------------------
module tb_mul_d_pipe;

    localparam int Q = 8380417;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [22:0] a_i;
    logic [22:0] b_i;
    logic [7:0]  tag_i;
    logic        valid_o;
    logic        ready_i;
    logic [45:0] product_o;
    logic [7:0]  tag_o;
    logic        err_o;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [45:0] p;
        logic [7:0]  t;
        logic        e;
    } expEntry_t;

    always #5 clk_i = ~clk_i;

    mul_d_pipe dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .a_i       (a_i),
        .b_i       (b_i),
        .tag_i     (tag_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .product_o (product_o),
        .tag_o     (tag_o),
        .err_o     (err_o)
    );

    // Inputs change on the falling edge; the DUT samples on the rising edge.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    function automatic logic [45:0] refMul(input logic [22:0] a, input logic [22:0] b);
        longint prod;
        prod = longint'(a) * longint'(b);
        return prod[45:0];
    endfunction

    function automatic logic refFlag(input logic [22:0] a, input logic [22:0] b);
`ifdef MUL_D_RANGE_CHECK_EN
        return (int'(a) >= Q) || (int'(b) >= Q);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [22:0] pickOperand();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 23'(Q - 1);
        if (r == 1) return 23'($urandom_range(Q, 8388607));
        return 23'($urandom_range(0, Q - 1));
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        a_i = '0; b_i = '0; tag_i = '0;
        repeat (2) @(negedge clk_i);
        nCompared++;
        if (valid_o !== 1'b0 || product_o !== 46'd0 || tag_o !== 8'd0 || err_o !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: valid=%b product=%0d tag=%0h err=%b, want all 0",
                     valid_o, product_o, tag_o, err_o);
        end
        nCompared++;
        if (ready_o !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reset_ready: got %b want 1", ready_o);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single();
        ready_i = 1'b1; valid_i = 1'b1;
        a_i = 23'd838041; b_i = 23'd1; tag_i = 8'h05;
        #1;
        nCompared++;
        if (ready_o !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL single_ready: got %b want 1", ready_o);
        end
        tick();
        valid_i = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            nCompared++;
            if (valid_o !== (cyc == 3)) begin
                nMismatched++;
                $display("[TB] FAIL single_latency cycle %0d: valid_o=%b want %b", cyc, valid_o, (cyc == 3));
            end
            if (cyc == 3) begin
                nCompared++;
                if (product_o !== 46'd838041 || tag_o !== 8'h05) begin
                    nMismatched++;
                    $display("[TB] FAIL single_value: product=%0d tag=%0h want 838041 tag 05", product_o, tag_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_max();
        ready_i = 1'b1; valid_i = 1'b1;
        a_i = 23'(Q - 1); b_i = 23'(Q - 1); tag_i = 8'hAA;
        tick();
        valid_i = 1'b0;
        tick(); tick();
        nCompared++;
        if (valid_o !== 1'b1 || product_o !== 46'd70231372333056 || tag_o !== 8'hAA) begin
            nMismatched++;
            $display("[TB] FAIL max_product: valid=%b product=%0d tag=%0h want 1 70231372333056 aa",
                     valid_o, product_o, tag_o);
        end
        nCompared++;
        if ((longint'(product_o) % longint'(Q)) !== 64'sd1) begin
            nMismatched++;
            $display("[TB] FAIL max_mod_q: got %0d want 1", longint'(product_o) % longint'(Q));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [22:0] opA [3];
        logic [22:0] opB [3];
        logic [45:0] want [3];
        opA[0] = 23'd4096;    opB[0] = 23'd4096;    want[0] = 46'd16777216;
        opA[1] = 23'd1234567; opB[1] = 23'd7654321; want[1] = 46'd9449772114007;
        opA[2] = 23'd0;       opB[2] = 23'd8380416; want[2] = 46'd0;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; a_i = opA[i]; b_i = opB[i]; tag_i = 8'(8'h10 + i);
            #1;
            nCompared++;
            if (ready_o !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL b2b_ready op %0d: got %b want 1", i, ready_o);
            end
            tick();
        end
        valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nCompared++;
            if (i < 3) begin
                if (valid_o !== 1'b1 || product_o !== want[i] || tag_o !== 8'(8'h10 + i)) begin
                    nMismatched++;
                    $display("[TB] FAIL b2b_out %0d: valid=%b product=%0d tag=%0h want 1 %0d %0h",
                             i, valid_o, product_o, tag_o, want[i], 8'(8'h10 + i));
                end
            end else if (valid_o !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL b2b_tail: valid_o=%b want 0", valid_o);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [22:0] opA [5];
        logic [22:0] opB [5];
        logic [45:0] heldP;
        logic        heldSeen;
        int          acc;
        int          got;
        for (int i = 0; i < 5; i++) begin
            opA[i] = pickOperand();
            opB[i] = pickOperand();
        end
        acc = 0; got = 0; heldSeen = 1'b0; heldP = '0;
        ready_i = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            valid_i = (acc < 5);
            if (acc < 5) begin a_i = opA[acc]; b_i = opB[acc]; tag_i = 8'(8'h40 + acc); end
            #1;
            if (heldSeen) begin
                nCompared++;
                if (valid_o !== 1'b1 || product_o !== heldP || tag_o !== 8'h40) begin
                    nMismatched++;
                    $display("[TB] FAIL bp_hold cycle %0d: valid=%b product=%0d tag=%0h want 1 %0d 40",
                             cyc, valid_o, product_o, tag_o, heldP);
                end
            end else if (valid_o === 1'b1) begin
                heldSeen = 1'b1;
                heldP    = product_o;
                nCompared++;
                if (product_o !== refMul(opA[0], opB[0])) begin
                    nMismatched++;
                    $display("[TB] FAIL bp_first: got %0d want %0d", product_o, refMul(opA[0], opB[0]));
                end
            end
            if (valid_i && ready_o) acc++;
            tick();
        end
        nCompared++;
        if (acc !== 3 || ready_o !== 1'b0 || !heldSeen) begin
            nMismatched++;
            $display("[TB] FAIL bp_capacity: accepted=%0d ready_o=%b held=%b want 3 0 1", acc, ready_o, heldSeen);
        end
        ready_i = 1'b1;
        for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
            valid_i = (acc < 5);
            if (acc < 5) begin a_i = opA[acc]; b_i = opB[acc]; tag_i = 8'(8'h40 + acc); end
            #1;
            if (valid_o === 1'b1) begin
                nCompared++;
                if (product_o !== refMul(opA[got], opB[got]) || tag_o !== 8'(8'h40 + got)) begin
                    nMismatched++;
                    $display("[TB] FAIL bp_drain %0d: product=%0d tag=%0h want %0d %0h",
                             got, product_o, tag_o, refMul(opA[got], opB[got]), 8'(8'h40 + got));
                end
                got++;
            end
            if (valid_i && ready_o) acc++;
            tick();
        end
        valid_i = 1'b0;
        nCompared++;
        if (got !== 5 || acc !== 5) begin
            nMismatched++;
            $display("[TB] FAIL bp_count: drained=%0d accepted=%0d want 5 5", got, acc);
        end
        tick(); tick();
        nCompared++;
        if (valid_o !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL bp_duplicate: valid_o=%b want 0", valid_o);
        end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1; a_i = 23'(1000 + i); b_i = 23'd7; tag_i = 8'(8'h70 + i);
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        tick();
        nCompared++;
        if (valid_o !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_inflight: valid_o=%b want 1", valid_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        nCompared++;
        if (valid_o !== 1'b0 || product_o !== 46'd0) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_async: valid=%b product=%0d want 0 0", valid_o, product_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        ready_i = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick();
            nCompared++;
            if (valid_o !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL rstmid_stale cycle %0d: valid_o=%b want 0", cyc, valid_o);
            end
        end
        valid_i = 1'b1; a_i = 23'd12345; b_i = 23'd678; tag_i = 8'h7E;
        tick();
        valid_i = 1'b0;
        tick(); tick();
        nCompared++;
        if (valid_o !== 1'b1 || product_o !== refMul(23'd12345, 23'd678) || tag_o !== 8'h7E) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_new: valid=%b product=%0d tag=%0h want 1 %0d 7e",
                     valid_o, product_o, tag_o, refMul(23'd12345, 23'd678));
        end
        tick();
    endtask

`ifdef MUL_D_RANGE_CHECK_EN
    task automatic test_range_check();
        ready_i = 1'b1;
        valid_i = 1'b1; a_i = 23'd8380417; b_i = 23'd2; tag_i = 8'h01;
        tick();
        a_i = 23'd3; b_i = 23'd3; tag_i = 8'h02;
        tick();
        valid_i = 1'b0;
        tick();
        nCompared++;
        if (valid_o !== 1'b1 || product_o !== 46'd16760834 || err_o !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL range_err: valid=%b product=%0d err=%b want 1 16760834 1", valid_o, product_o, err_o);
        end
        tick();
        nCompared++;
        if (valid_o !== 1'b1 || product_o !== 46'd9 || err_o !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL range_ok: valid=%b product=%0d err=%b want 1 9 0", valid_o, product_o, err_o);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        expEntry_t   q[$];
        expEntry_t   ent;
        logic        holdPending;
        logic [45:0] holdP;
        logic [7:0]  holdT;
        holdPending = 1'b0; holdP = '0; holdT = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            a_i     = pickOperand();
            b_i     = pickOperand();
            tag_i   = 8'($urandom);
            #1;
            if (holdPending) begin
                nCompared++;
                if (valid_o !== 1'b1 || product_o !== holdP || tag_o !== holdT) begin
                    nMismatched++;
                    $display("[TB] FAIL rand_hold cycle %0d: valid=%b product=%0d tag=%0h want 1 %0d %0h",
                             cyc, valid_o, product_o, tag_o, holdP, holdT);
                end
            end
            holdPending = (valid_o === 1'b1) && !ready_i;
            holdP = product_o;
            holdT = tag_o;
            if (valid_o === 1'b1 && ready_i) begin
                nCompared++;
                if (q.size() == 0) begin
                    nMismatched++;
                    $display("[TB] FAIL rand_spurious cycle %0d: product=%0d with nothing expected", cyc, product_o);
                end else begin
                    ent = q.pop_front();
                    if (product_o !== ent.p || tag_o !== ent.t || err_o !== ent.e) begin
                        nMismatched++;
                        $display("[TB] FAIL rand_out cycle %0d: product=%0d tag=%0h err=%b want %0d %0h %b",
                                 cyc, product_o, tag_o, err_o, ent.p, ent.t, ent.e);
                    end
                end
            end
            if (valid_i && ready_o) begin
                ent.p = refMul(a_i, b_i);
                ent.t = tag_i;
                ent.e = refFlag(a_i, b_i);
                q.push_back(ent);
            end
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) begin
            #1;
            if (valid_o === 1'b1) begin
                nCompared++;
                ent = q.pop_front();
                if (product_o !== ent.p || tag_o !== ent.t || err_o !== ent.e) begin
                    nMismatched++;
                    $display("[TB] FAIL rand_drain: product=%0d tag=%0h err=%b want %0d %0h %b",
                             product_o, tag_o, err_o, ent.p, ent.t, ent.e);
                end
            end
            tick();
        end
        #1;
        nCompared++;
        if (q.size() != 0 || valid_o !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL rand_leftover: pending=%0d valid_o=%b want 0 0", q.size(), valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_max();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef MUL_D_RANGE_CHECK_EN
        test_range_check();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/mul_d_pipe.md
Name: mul_d_pipe

Overview:
- Pipelined 23x23-bit integer multiplier for Dilithium (q = 8380417).
- Sits directly upstream of the red_d Barrett reducer: its 46-bit product_o drives red_d.product_i.
- Valid/ready handshake on both sides, a 3-stage pipeline with backpressure, and a sideband tag carried with each product so downstream NTT/pointwise logic can track coefficient index.

Parameters:
- W, 23, operand width (bits)
- Q, 8380417, Dilithium modulus (used only by the optional range check)
- SPLIT, 12, width of low slice of operand b for partial products
- TAG_W, 8, sideband tag width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  input operands valid
- ready_o  out  1  block can accept operands this cycle
- a_i  in  W  operand a, expected in [0, Q-1]
- b_i  in  W  operand b, expected in [0, Q-1]
- tag_i  in  TAG_W  sideband tag
- valid_o  out  1  product valid
- ready_i  in  1  downstream (red_d consumer) ready
- product_o  out  2*W  a*b, unsigned, exact
- tag_o  out  TAG_W  tag accompanying product_o
- err_o  out  1  range error flag (only with MUL_D_RANGE_CHECK_EN; tied 0 otherwise)

Behaviour:
- Reset is asynchronous on rst_ni low; the block leaves reset on the first clk_i edge with rst_ni high.
  - All stage valid bits go to 0; valid_o = 0.
  - product_o = 0, tag_o = 0, err_o = 0.
  - Data registers are cleared to 0.
  - An in-flight transfer during reset is dropped silently.
- Transfer occurs on a clock edge when valid && ready on that interface. Inputs are sampled only on an accepted transfer.
- Stage S1: registers a, b and tag.
- Stage S2: registers the two partial products.
  - pp_lo = a * b[SPLIT-1:0], width W+SPLIT.
  - pp_hi = a * b[W-1:SPLIT], width 2W-SPLIT.
- Stage S3 (output register): product = (pp_hi << SPLIT) + pp_lo, truncated to 2W bits. No overflow is possible for W-bit operands.
- Latency is 3 cycles from accepted input to valid_o when not stalled. Throughput is 1 per cycle.
- Stall rules:
  - adv3 = !v3 || ready_i
  - adv2 = !v2 || adv3
  - adv1 = !v1 || adv2
  - ready_o = adv1 (combinational from ready_i).
  - Bubbles collapse: an empty stage accepts even when later stages are stalled.
- Capacity is 3 operations. With ready_i held low, exactly 3 inputs are accepted, then ready_o = 0.
- valid_o, product_o and tag_o stay stable while valid_o && !ready_i.
- Simultaneous accept on input and drain on output in the same cycle is a legal full-throughput case.
- Operands >= Q are still multiplied exactly. No masking is applied.

Optional Feature:
- Macro: MUL_D_RANGE_CHECK_EN.
- When defined:
  - S1 also registers flag = (a_i >= Q) || (b_i >= Q); the flag travels with the data.
  - err_o is asserted alongside valid_o for the affected product and obeys the same hold rule as the data.
  - product_o is still the exact product.
- When undefined:
  - No flag logic is built.
  - err_o is tied to 0.

Decomposition:
- Package dilithium_pkg holds:
  - constants Q_D = 8380417, W_D = 23
  - typedef coeff_t (logic [22:0])
  - typedef prod_t (logic [45:0])
  - This package is shared with red_d.
- One natural sub-module: mul_d_stage, a generic valid/ready pipeline register (payload width parameter, adv input, valid/ready logic). It is instantiated three times.

Test Plan:
- Reset then single op: a=838041, b=1, tag=0x05, ready_i=1.
  - product_o=838041 and tag_o=0x05 exactly 3 cycles after accept.
  - valid_o is high for one cycle.
- Max operands: a=b=8380416.
  - product_o=70231372333056.
  - Feeding red_d yields 1.
- Back-to-back stream with ready_i=1: (4096,4096), (1234567,7654321), (0,8380416).
  - Products 16777216, 9449772114007, 0 on consecutive cycles.
  - Tags stay in order.
- Backpressure: ready_i=0 while valid_i=1 with 5 ops.
  - Exactly 3 accepted; ready_o=0 from then on.
  - The first product is held stable.
  - Release ready_i: all 5 products emerge in order with no loss or duplication.
- Reset mid-operation: assert rst_ni=0 with 2 ops in flight.
  - valid_o=0 immediately (asynchronous).
  - After release, no stale products appear; a new op gives the correct result after 3 cycles.
- With MUL_D_RANGE_CHECK_EN: a=8380417, b=2.
  - product_o=16760834 with err_o=1.
  - The next op (3,3) gives 9 with err_o=0.
